// File: rtl/arch_defs_pkg.sv
// Architectural definitions shared by the status register and branch evaluation:
// data width, status byte bit positions and the branch condition encoding.
package arch_defs_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int STATUS_C_BIT = 0;
    localparam int STATUS_Z_BIT = 1;
    localparam int STATUS_N_BIT = 2;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'd0,
        COND_Z      = 3'd1,
        COND_NZ     = 3'd2,
        COND_C      = 3'd3,
        COND_NC     = 3'd4,
        COND_N      = 3'd5,
        COND_NN     = 3'd6,
        COND_NEVER  = 3'd7
    } cond_e;

    // Zero-extend the {N,Z,C} triple into a status byte.
    function automatic logic [DATA_WIDTH-1:0] pack_status(input logic [2:0] flags);
        logic [DATA_WIDTH-1:0] s;
        s = '0;
        s[STATUS_N_BIT] = flags[STATUS_N_BIT];
        s[STATUS_Z_BIT] = flags[STATUS_Z_BIT];
        s[STATUS_C_BIT] = flags[STATUS_C_BIT];
        return s;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation: (flags, cond_e) -> branch_taken.
module branch_cond_eval
    import arch_defs_pkg::*;
(
    input  logic [2:0] flags,
    input  cond_e      cond_sel,
    output logic       branch_taken
);

    always_comb begin
        branch_taken = 1'b0;
        unique case (cond_sel)
            COND_ALWAYS: branch_taken = 1'b1;
            COND_Z:      branch_taken = flags[STATUS_Z_BIT];
            COND_NZ:     branch_taken = ~flags[STATUS_Z_BIT];
            COND_C:      branch_taken = flags[STATUS_C_BIT];
            COND_NC:     branch_taken = ~flags[STATUS_C_BIT];
            COND_N:      branch_taken = flags[STATUS_N_BIT];
            COND_NN:     branch_taken = ~flags[STATUS_N_BIT];
            COND_NEVER:  branch_taken = 1'b0;
            default:     branch_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/status_flags_reg.sv
// Architectural N/Z/C status register with ALU capture, SEC/CLC, PHP/PLP and branch evaluation.
// Define STATUS_REG_SHADOW_EN to add an interrupt shadow copy saved/restored by irq_entry/irq_return.
module status_flags_reg
    import arch_defs_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_zero_flag,
    input  logic                  alu_carry_flag,
    input  logic                  alu_negative_flag,
    input  logic                  load_alu_flags,
    input  logic [2:0]            flag_mask,
    input  logic                  set_carry,
    input  logic                  clear_carry,
    input  logic                  load_from_bus,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic [2:0]            cond_sel,
    input  logic                  irq_entry,
    input  logic                  irq_return,
    output logic [DATA_WIDTH-1:0] status_out,
    output logic                  carry_flag,
    output logic                  zero_flag,
    output logic                  negative_flag,
    output logic                  branch_taken
);

    localparam logic [2:0] FLAGS_RST = 3'b010;

    logic [2:0] flags_q, flags_d;
    logic [2:0] alu_flags;
    logic       restore;
    logic [2:0] shadow_val;

    assign alu_flags = {alu_negative_flag, alu_zero_flag, alu_carry_flag};

`ifdef STATUS_REG_SHADOW_EN
    logic [2:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        // A simultaneous return wins: the shadow is being consumed, not refilled.
        if (irq_entry && !irq_return) shadow_d = flags_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) shadow_q <= FLAGS_RST;
        else       shadow_q <= shadow_d;
    end

    assign restore    = irq_return;
    assign shadow_val = shadow_q;
`else
    logic unused_irq;
    assign unused_irq = irq_entry ^ irq_return;
    assign restore    = 1'b0;
    assign shadow_val = FLAGS_RST;
`endif

    always_comb begin
        flags_d = flags_q;
        if (restore) begin
            flags_d = shadow_val;
        end else if (load_from_bus) begin
            flags_d = bus_in[2:0];
        end else begin
            if (load_alu_flags) begin
                for (int i = 0; i < 3; i++)
                    if (flag_mask[i]) flags_d[i] = alu_flags[i];
            end
            // Carry falls through to CLC/SEC when the ALU load leaves it unmasked.
            if (!(load_alu_flags && flag_mask[STATUS_C_BIT])) begin
                if (clear_carry)    flags_d[STATUS_C_BIT] = 1'b0;
                else if (set_carry) flags_d[STATUS_C_BIT] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) flags_q <= FLAGS_RST;
        else       flags_q <= flags_d;
    end

    logic unused_bus;
    assign unused_bus = ^bus_in[DATA_WIDTH-1:3];

    assign status_out    = pack_status(flags_q);
    assign carry_flag    = flags_q[STATUS_C_BIT];
    assign zero_flag     = flags_q[STATUS_Z_BIT];
    assign negative_flag = flags_q[STATUS_N_BIT];

    branch_cond_eval u_branch_cond_eval (
        .flags        (flags_q),
        .cond_sel     (cond_e'(cond_sel)),
        .branch_taken (branch_taken)
    );

endmodule

// File: tb/tb_status_flags_reg.sv
// Self-checking bench for status_flags_reg: directed scenarios plus a randomized priority mix
// checked against a rule-level reference model of the flags and shadow.
module tb_status_flags_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_zero_flag, alu_carry_flag, alu_negative_flag;
    logic       load_alu_flags;
    logic [2:0] flag_mask;
    logic       set_carry, clear_carry, load_from_bus;
    logic [7:0] bus_in;
    logic [2:0] cond_sel;
    logic       irq_entry, irq_return;
    logic [7:0] status_out;
    logic       carry_flag, zero_flag, negative_flag, branch_taken;

    int total = 0;
    int bad   = 0;

    // Reference state, indexed {N,Z,C}.
    logic [2:0] m_f, m_sh;

    status_flags_reg dut (
        .clk(clk), .reset(reset),
        .alu_zero_flag(alu_zero_flag), .alu_carry_flag(alu_carry_flag),
        .alu_negative_flag(alu_negative_flag),
        .load_alu_flags(load_alu_flags), .flag_mask(flag_mask),
        .set_carry(set_carry), .clear_carry(clear_carry),
        .load_from_bus(load_from_bus), .bus_in(bus_in), .cond_sel(cond_sel),
        .irq_entry(irq_entry), .irq_return(irq_return),
        .status_out(status_out), .carry_flag(carry_flag), .zero_flag(zero_flag),
        .negative_flag(negative_flag), .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

    function automatic logic exp_branch(input int sel, input logic [2:0] f);
        case (sel)
            0: return 1'b1;
            1: return f[1];
            2: return !f[1];
            3: return f[0];
            4: return !f[0];
            5: return f[2];
            6: return !f[2];
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle();
        {alu_zero_flag, alu_carry_flag, alu_negative_flag} = 3'b000;
        load_alu_flags = 0; flag_mask = 3'b000;
        set_carry = 0; clear_carry = 0; load_from_bus = 0; bus_in = 8'h00;
        irq_entry = 0; irq_return = 0;
    endtask

    // Advance one clock edge, applying the architectural update rules to the model.
    task automatic tick();
        logic [2:0] nf, nsh;
        nf = m_f; nsh = m_sh;
`ifdef STATUS_REG_SHADOW_EN
        if (irq_entry && !irq_return) nsh = m_f;
        if (irq_return) nf = m_sh;
        else
`endif
        if (load_from_bus) nf = bus_in[2:0];
        else begin
            if (load_alu_flags) begin
                if (flag_mask[0]) nf[0] = alu_carry_flag;
                if (flag_mask[1]) nf[1] = alu_zero_flag;
                if (flag_mask[2]) nf[2] = alu_negative_flag;
            end
            if (!(load_alu_flags && flag_mask[0])) begin
                if (clear_carry)    nf[0] = 1'b0;
                else if (set_carry) nf[0] = 1'b1;
            end
        end
        @(posedge clk);
        m_f = nf; m_sh = nsh;
        #1;
    endtask

    task automatic test_reset();
        idle(); cond_sel = 3'd0;
        reset = 1'b1;
        m_f = 3'b010; m_sh = 3'b010;
        #3;
        total++;
        if (status_out !== 8'h02 || {negative_flag, zero_flag, carry_flag} !== 3'b010) begin
            bad++;
            $display("FAIL reset_state: status_out=%h flags=%b, want 02 / 010", status_out,
                     {negative_flag, zero_flag, carry_flag});
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_alu_mask();
        idle();
        {alu_negative_flag, alu_zero_flag, alu_carry_flag} = 3'b101;
        load_alu_flags = 1; flag_mask = 3'b101;
        tick(); idle();
        total++;
        if (status_out !== 8'h07 || status_out !== {5'd0, m_f}) begin
            bad++;
            $display("FAIL alu_mask: status_out=%h want 07", status_out);
        end
        // Mask 000 is a no-op even with ALU values differing.
        {alu_negative_flag, alu_zero_flag, alu_carry_flag} = 3'b000;
        load_alu_flags = 1; flag_mask = 3'b000;
        tick(); idle();
        total++;
        if (status_out !== 8'h07) begin
            bad++;
            $display("FAIL alu_mask_zero: status_out=%h want 07", status_out);
        end
        // Unmasked carry still takes CLC in the same cycle.
        {alu_negative_flag, alu_zero_flag, alu_carry_flag} = 3'b001;
        load_alu_flags = 1; flag_mask = 3'b110; clear_carry = 1;
        tick(); idle();
        total++;
        if ({negative_flag, zero_flag, carry_flag} !== 3'b000 || m_f !== 3'b000) begin
            bad++;
            $display("FAIL alu_carry_fallthrough: flags=%b want 000",
                     {negative_flag, zero_flag, carry_flag});
        end
    endtask

    task automatic test_carry_priority();
        idle(); set_carry = 1; tick(); idle();
        total++;
        if (carry_flag !== 1'b1) begin
            bad++; $display("FAIL sec: carry=%b want 1", carry_flag);
        end
        set_carry = 1; clear_carry = 1; tick(); idle();
        total++;
        if (carry_flag !== 1'b0) begin
            bad++; $display("FAIL sec_clc: carry=%b want 0", carry_flag);
        end
        load_from_bus = 1; bus_in = 8'hFC; set_carry = 1; tick(); idle();
        total++;
        if ({negative_flag, zero_flag, carry_flag} !== 3'b100 || status_out !== 8'h04) begin
            bad++;
            $display("FAIL plp_over_sec: flags=%b status=%h want 100 / 04",
                     {negative_flag, zero_flag, carry_flag}, status_out);
        end
    endtask

    task automatic test_branch_sweep();
        for (int f = 0; f < 8; f++) begin
            idle(); load_from_bus = 1; bus_in = 8'(f);
            cond_sel = 3'd1;
            #1;
            // Before the edge the new value must not bypass into branch_taken.
            total++;
            if (branch_taken !== exp_branch(1, m_f)) begin
                bad++;
                $display("FAIL branch_latency: f=%0d got=%b want=%b", f, branch_taken,
                         exp_branch(1, m_f));
            end
            tick(); idle();
            for (int s = 0; s < 8; s++) begin
                cond_sel = 3'(s); #1;
                total++;
                if (branch_taken !== exp_branch(s, 3'(f))) begin
                    bad++;
                    $display("FAIL branch_table: flags=%0d cond=%0d got=%b want=%b", f, s,
                             branch_taken, exp_branch(s, 3'(f)));
                end
            end
        end
    endtask

    task automatic test_shadow();
        idle(); load_from_bus = 1; bus_in = 8'h03; tick(); idle();
        irq_entry = 1; tick(); idle();
        load_from_bus = 1; bus_in = 8'h04; tick(); idle();
        irq_return = 1; irq_entry = 1; tick(); idle();
        total++;
`ifdef STATUS_REG_SHADOW_EN
        if ({negative_flag, zero_flag, carry_flag} !== 3'b011) begin
            bad++;
            $display("FAIL shadow_restore: flags=%b want 011", {negative_flag, zero_flag, carry_flag});
        end
`else
        if ({negative_flag, zero_flag, carry_flag} !== 3'b100) begin
            bad++;
            $display("FAIL shadow_absent: flags=%b want 100", {negative_flag, zero_flag, carry_flag});
        end
`endif
    endtask

    task automatic test_reset_mid();
        idle(); load_from_bus = 1; bus_in = 8'h05; tick(); idle();
        irq_entry = 1; tick(); idle();
        #2; reset = 1'b1; m_f = 3'b010; m_sh = 3'b010; #1;
        total++;
        if (status_out !== 8'h02 || {negative_flag, zero_flag, carry_flag} !== 3'b010) begin
            bad++;
            $display("FAIL reset_mid: status=%h flags=%b want 02 / 010", status_out,
                     {negative_flag, zero_flag, carry_flag});
        end
        @(posedge clk); #1; reset = 1'b0;
        // Shadow must also have been reset.
        irq_return = 1; tick(); idle();
        total++;
        if (status_out !== 8'h02) begin
            bad++; $display("FAIL reset_shadow: status=%h want 02", status_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            {alu_negative_flag, alu_zero_flag, alu_carry_flag} = 3'($urandom);
            load_alu_flags = ($urandom_range(0, 2) == 0);
            flag_mask      = 3'($urandom);
            set_carry      = ($urandom_range(0, 2) == 0);
            clear_carry    = ($urandom_range(0, 2) == 0);
            load_from_bus  = ($urandom_range(0, 4) == 0);
            bus_in         = 8'($urandom);
            irq_entry      = ($urandom_range(0, 5) == 0);
            irq_return     = ($urandom_range(0, 7) == 0);
            cond_sel       = 3'($urandom);
            tick();
            total++;
            if ($isunknown({status_out, carry_flag, zero_flag, negative_flag, branch_taken}) ||
                status_out !== {5'd0, m_f} ||
                {negative_flag, zero_flag, carry_flag} !== m_f ||
                branch_taken !== exp_branch(int'(cond_sel), m_f)) begin
                bad++;
                $display("FAIL random[%0d]: status=%h flags=%b br=%b want flags=%b br=%b", i,
                         status_out, {negative_flag, zero_flag, carry_flag}, branch_taken,
                         m_f, exp_branch(int'(cond_sel), m_f));
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_alu_mask();
        test_carry_priority();
        test_branch_sweep();
        test_shadow();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
